// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction-fetch port (i_*), the data port
// (d_*), the single-ported memory port (m_*) and the pipeline stall outputs
// of the memory arbiter.
//   slave  modport: the arbiter side (takes requests, drives memory/stalls)
//   master modport: the environment side (core ports and the memory)
interface mem_arbiter_if #(
  parameter int WIDTH = 32
) ();
  // instruction-fetch port
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic [WIDTH-1:0] i_rdata;
  logic             i_ready;
  // data port
  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic [WIDTH-1:0] d_rdata;
  logic             d_ready;
  // memory port
  logic             m_en;
  logic             m_we;
  logic [WIDTH-1:0] m_addr;
  logic [WIDTH-1:0] m_wdata;
  logic [WIDTH-1:0] m_rdata;
  // pipeline stalls
  logic             stall_f;
  logic             stall_m;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready,
    output m_en, m_we, m_addr, m_wdata, stall_f, stall_m
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready,
    input  m_en, m_we, m_addr, m_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, word-addressed memory between the
// instruction-fetch (I) and data (D) ports of the pipelined core. Each access
// is a grant cycle, LATENCY memory cycles with m_en held, and one completion
// cycle carrying a one-cycle ready pulse to the owner.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   bus   - mem_arbiter_if.slave: I/D request ports, memory port, stalls
// Parameters:
//   LATENCY - memory cycles per access (1..15)
//   WIDTH   - address and data width
module mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // control state
  logic [1:0]       state_r, state_next_s;
  logic [3:0]       cnt_r, cnt_next_s;
  logic             owner_d_r, owner_d_next_s;  // 1 = D owns the access
  logic             last_d_r, last_d_next_s;    // 1 = last grant went to D
  logic             we_r, we_next_s;
  logic [WIDTH-1:0] addr_r, addr_next_s;
  logic [WIDTH-1:0] wdata_r, wdata_next_s;

  // registered outputs
  logic [WIDTH-1:0] i_rdata_r, d_rdata_r;
  logic             i_ready_r, d_ready_r;
  logic             m_en_r, m_we_r;
  logic [WIDTH-1:0] m_addr_r, m_wdata_r;

  logic             busy_next_s;
  logic             capture_s;

  // Arbitration and sequencing: next state and latched request fields.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    owner_d_next_s = owner_d_r;
    last_d_next_s  = last_d_r;
    we_next_s      = we_r;
    addr_next_s    = addr_r;
    wdata_next_s   = wdata_r;
    case (state_r)
      IDLE: begin
        // D wins a tie unless it won the previous grant, so neither port starves.
        if (bus.d_req && !(bus.i_req && last_d_r)) begin
          state_next_s   = BUSY;
          cnt_next_s     = CNT_INIT;
          owner_d_next_s = 1'b1;
          last_d_next_s  = 1'b1;
          we_next_s      = bus.d_we;
          addr_next_s    = bus.d_addr;
          wdata_next_s   = bus.d_wdata;
        end else if (bus.i_req) begin
          state_next_s   = BUSY;
          cnt_next_s     = CNT_INIT;
          owner_d_next_s = 1'b0;
          last_d_next_s  = 1'b0;
          we_next_s      = 1'b0;
          addr_next_s    = bus.i_addr;
          wdata_next_s   = {WIDTH{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          state_next_s = DONE;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        // No arbitration here: the owner's req is still high during its
        // ready pulse and must not be granted a second time.
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  assign busy_next_s = (state_next_s == BUSY);
  // Read data is sampled in the final BUSY cycle; writes leave rdata untouched.
  assign capture_s   = (state_r == BUSY) && (cnt_r == 4'd0) && !we_r;

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      owner_d_r <= 1'b0;
      last_d_r  <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= {WIDTH{1'b0}};
      wdata_r   <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      owner_d_r <= owner_d_next_s;
      last_d_r  <= last_d_next_s;
      we_r      <= we_next_s;
      addr_r    <= addr_next_s;
      wdata_r   <= wdata_next_s;
    end
  end

  // Output registers, loaded from next-state values so they line up with
  // the state they describe; m_we only in the last BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en_r    <= 1'b0;
      m_we_r    <= 1'b0;
      m_addr_r  <= {WIDTH{1'b0}};
      m_wdata_r <= {WIDTH{1'b0}};
      i_ready_r <= 1'b0;
      d_ready_r <= 1'b0;
    end else begin
      m_en_r    <= busy_next_s;
      m_we_r    <= busy_next_s && (cnt_next_s == 4'd0) && we_next_s;
      m_addr_r  <= busy_next_s ? addr_next_s : {WIDTH{1'b0}};
      m_wdata_r <= busy_next_s ? wdata_next_s : {WIDTH{1'b0}};
      i_ready_r <= (state_next_s == DONE) && !owner_d_next_s;
      d_ready_r <= (state_next_s == DONE) && owner_d_next_s;
    end
  end

  // Read-data holding registers for each port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata_r <= {WIDTH{1'b0}};
      d_rdata_r <= {WIDTH{1'b0}};
    end else if (capture_s) begin
      if (owner_d_r) begin
        d_rdata_r <= bus.m_rdata;
      end else begin
        i_rdata_r <= bus.m_rdata;
      end
    end else begin
      i_rdata_r <= i_rdata_r;
      d_rdata_r <= d_rdata_r;
    end
  end

  assign bus.i_rdata = i_rdata_r;
  assign bus.d_rdata = d_rdata_r;
  assign bus.i_ready = i_ready_r;
  assign bus.d_ready = d_ready_r;
  assign bus.m_en    = m_en_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  // Stalls follow the live request so the pipeline freezes in the request cycle.
  assign bus.stall_f = bus.i_req & ~i_ready_r;
  assign bus.stall_m = bus.d_req & ~d_ready_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a LATENCY=2 instance driven from a
// vector table plus arbitration/reset sequences, and a LATENCY=1 instance
// for back-to-back fetches. Each instance has a word memory model.
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic clk;
  logic reset;
  logic init_mem;

  mem_arbiter_if #(.WIDTH(32)) bus ();
  mem_arbiter_if #(.WIDTH(32)) bus1 ();

  mem_arbiter #(.LATENCY(LAT), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  mem_arbiter #(.LATENCY(1), .WIDTH(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic        is_d;
    logic        we;
    logic        scr;       // scramble the port inputs after grant
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vt[8];
  int          n_chk = 0;
  int          n_pass = 0;
  int          we_seen;
  logic [31:0] mem[0:63];
  logic [31:0] mem1[0:63];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'h2002_0003 + {26'd0, a[7:2]};
  endfunction

  always #5 clk = ~clk;

  // memory models: combinational read, write on the clock edge
  assign bus.m_rdata  = mem[bus.m_addr[7:2]];
  assign bus1.m_rdata = mem1[bus1.m_addr[7:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 64; k++) begin
        mem[k]  <= init_val(32'(k) << 2);
        mem1[k] <= init_val(32'(k) << 2);
      end
      we_seen <= 0;
    end else begin
      if (bus.m_we) begin
        mem[bus.m_addr[7:2]] <= bus.m_wdata;
        we_seen <= we_seen + 1;
      end
      if (bus1.m_we) mem1[bus1.m_addr[7:2]] <= bus1.m_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".i_rdata"}, bus.i_rdata, 32'h0);
    check({tag, ".d_rdata"}, bus.d_rdata, 32'h0);
    check({tag, ".m_addr"}, bus.m_addr, 32'h0);
    check({tag, ".m_wdata"}, bus.m_wdata, 32'h0);
    check({tag, ".ctrl"}, {28'd0, bus.i_ready, bus.d_ready, bus.m_en, bus.m_we}, 32'h0);
  endtask

  task automatic do_vec(input vec_t v, input int idx);
    logic [31:0] prev_i, prev_d, wd;
    int en_n, we_n, we_c, rdy_c, bad_addr, other_rdy;
    bit got;
    exp_t e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    en_n = 0; we_n = 0; we_c = -1; rdy_c = -1; bad_addr = 0; other_rdy = 0;
    got = 1'b0; wd = 32'h0;
    @(negedge clk);
    prev_i = bus.i_rdata;
    prev_d = bus.d_rdata;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    sbq.push_back('{v.is_d, v.we, v.exp_rdata});
    #1;
    check({tag, ".stall_c0"}, 32'(v.is_d ? bus.stall_m : bus.stall_f), 32'd1);
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.m_en) begin
        en_n++;
        if (bus.m_addr !== v.addr) bad_addr++;
      end
      if (bus.m_we) begin
        we_n++; we_c = c; wd = bus.m_wdata;
      end
      if ((v.is_d ? bus.i_ready : bus.d_ready) == 1'b1) other_rdy++;
      if ((v.is_d ? bus.d_ready : bus.i_ready) == 1'b1) begin
        got = 1'b1;
        rdy_c = c;
        check({tag, ".stall_rdy"}, 32'(v.is_d ? bus.stall_m : bus.stall_f), 32'd0);
        check({tag, ".sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          if (!e.we) check({tag, ".rdata"}, e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
          else check({tag, ".wr_keeps_d"}, bus.d_rdata, prev_d);
          check({tag, ".other_rdata"}, e.is_d ? bus.i_rdata : bus.d_rdata,
                e.is_d ? prev_i : prev_d);
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.d_we = 1'b0;
      end else if (c == 1 && v.scr) begin
        // inputs change after grant; the latched request must win
        if (v.is_d) begin
          bus.d_addr = 32'h3C; bus.d_wdata = ~v.wdata;
        end else begin
          bus.i_addr = 32'h3C;
        end
      end
    end
    check({tag, ".ready_seen"}, 32'(got), 32'd1);
    bus.d_req = 1'b0; bus.i_req = 1'b0; bus.d_we = 1'b0;
    check({tag, ".ready_cycle"}, 32'(rdy_c), 32'(LAT + 1));
    check({tag, ".m_en_cycles"}, 32'(en_n), 32'(LAT));
    check({tag, ".m_we_count"}, 32'(we_n), 32'(v.we));
    if (v.we) begin
      check({tag, ".m_we_cycle"}, 32'(we_c), 32'(LAT));
      check({tag, ".m_wdata"}, wd, v.wdata);
    end
    check({tag, ".m_addr_bad"}, 32'(bad_addr), 32'd0);
    check({tag, ".other_ready"}, 32'(other_rdy), 32'd0);
  endtask

  task automatic run_both(input int nd, input int ni, input logic [31:0] dbase,
                          input logic [31:0] ibase, output int d_first, output int i_first,
                          output logic [7:0] ord, output int max_run);
    int dn, in_n, c, run;
    logic [31:0] q_d[$], q_i[$];
    logic [31:0] ev;
    dn = 0; in_n = 0; c = 0; d_first = -1; i_first = -1; ord = 8'd0;
    @(negedge clk);
    if (nd > 0) begin
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = dbase; q_d.push_back(init_val(dbase));
    end
    if (ni > 0) begin
      bus.i_req = 1'b1; bus.i_addr = ibase; q_i.push_back(init_val(ibase));
    end
    run = (ni > 0) ? 1 : 0;
    max_run = run;
    while ((dn < nd || in_n < ni) && c < 80) begin
      @(negedge clk);
      c++;
      if (bus.stall_f) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.d_ready) begin
        if (d_first < 0) d_first = c;
        ord = {ord[6:0], 1'b1};
        check("both.d_sb", 32'(q_d.size()), 32'd1);
        if (q_d.size() > 0) begin
          ev = q_d.pop_front();
          check("both.d_rdata", bus.d_rdata, ev);
        end
        dn++;
        if (dn < nd) begin
          bus.d_addr = dbase + 32'(4 * dn); q_d.push_back(init_val(bus.d_addr));
        end else bus.d_req = 1'b0;
      end
      if (bus.i_ready) begin
        if (i_first < 0) i_first = c;
        ord = {ord[6:0], 1'b0};
        check("both.i_sb", 32'(q_i.size()), 32'd1);
        if (q_i.size() > 0) begin
          ev = q_i.pop_front();
          check("both.i_rdata", bus.i_rdata, ev);
        end
        in_n++;
        if (in_n < ni) begin
          bus.i_addr = ibase + 32'(4 * in_n); q_i.push_back(init_val(bus.i_addr));
        end else bus.i_req = 1'b0;
      end
    end
    check("both.complete", 32'(dn + in_n), 32'(nd + ni));
    bus.d_req = 1'b0; bus.i_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_first, i_first, max_run, wcnt0, n, c, en1, extra;
    int rc[3];
    logic [7:0] ord;
    logic [31:0] ev;
    logic [31:0] q1[$];

    clk = 1'b0; reset = 1'b1; init_mem = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    bus1.i_req = 1'b0; bus1.i_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = 32'h0; bus1.d_wdata = 32'h0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;
    check_zero("reset");
    check("reset.stalls", {30'd0, bus.stall_f, bus.stall_m}, 32'h0);
    reset = 1'b0;

    //           is_d  we    scr   addr    wdata          exp_rdata
    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h08, 32'h0,         32'h2002_0005};
    vt[1] = '{1'b1, 1'b1, 1'b0, 32'h54, 32'hDEAD_BEEF, 32'h0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h54, 32'h0,         32'hDEAD_BEEF};
    vt[3] = '{1'b0, 1'b0, 1'b0, 32'h00, 32'h0,         32'h2002_0003};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 32'h0};
    vt[5] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'h0,         32'h1234_5678};
    vt[6] = '{1'b1, 1'b0, 1'b1, 32'h04, 32'h0,         32'h2002_0004};
    vt[7] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,         32'h1234_5678};
    for (int v = 0; v < 8; v++) do_vec(vt[v], v);

    // simultaneous requests straight out of reset: D first, then I
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    run_both(1, 1, 32'h04, 32'h08, d_first, i_first, ord, max_run);
    check("arb.d_ready_cycle", 32'(d_first), 32'd3);
    check("arb.i_ready_cycle", 32'(i_first), 32'd7);
    check("arb.order", {24'd0, ord}, 32'h02);

    // D held for three accesses with I pending: strict alternation
    run_both(3, 2, 32'h20, 32'h30, d_first, i_first, ord, max_run);
    check("alt.order", {24'd0, ord}, 32'h15);
    check("alt.stall_f_bound", 32'(max_run <= 8), 32'd1);

    // reset in the first BUSY cycle of a write aborts it
    @(negedge clk);
    wcnt0 = we_seen;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("abort.busy", 32'(bus.m_en), 32'd1);
    reset = 1'b1;
    #1;
    check_zero("abort");
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort.no_write", 32'(we_seen - wcnt0), 32'd0);
    check("abort.mem_intact", mem[16], init_val(32'h40));
    do_vec('{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2002_0013}, 8);

    // LATENCY=1 instance: back-to-back fetches every 3 cycles
    n = 0; c = 0; en1 = 0; extra = 0;
    rc[0] = -1; rc[1] = -1; rc[2] = -1;
    @(negedge clk);
    bus1.i_req = 1'b1; bus1.i_addr = 32'h0; q1.push_back(init_val(32'h0));
    while (n < 3 && c < 30) begin
      @(negedge clk);
      c++;
      if (bus1.m_en) en1++;
      if (bus1.i_ready) begin
        rc[n] = c;
        check("lat1.sb", 32'(q1.size()), 32'd1);
        if (q1.size() > 0) begin
          ev = q1.pop_front();
          check("lat1.i_rdata", bus1.i_rdata, ev);
        end
        n++;
        if (n < 3) begin
          bus1.i_addr = 32'(4 * n); q1.push_back(init_val(bus1.i_addr));
        end else bus1.i_req = 1'b0;
      end
    end
    bus1.i_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus1.m_en) en1++;
      if (bus1.i_ready) extra++;
    end
    check("lat1.count", 32'(n), 32'd3);
    check("lat1.ready0", 32'(rc[0]), 32'd2);
    check("lat1.ready1", 32'(rc[1]), 32'd5);
    check("lat1.ready2", 32'(rc[2]), 32'd8);
    check("lat1.m_en_cycles", 32'(en1), 32'd3);
    check("lat1.no_extra", 32'(extra), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, word-addressed memory between the instruction-fetch port (I) and the data port (D) of the pipelined MIPS core.
- Sequences each access over a fixed number of memory cycles.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Drives the fetch and memory stage stall signals while a request is pending.

Parameters:
- LATENCY, 2, memory cycles per access (legal range 1..15); m_en is held for exactly LATENCY cycles.
- WIDTH, 32, address and data width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  fetch request; held high until i_ready
- i_addr  input  WIDTH  fetch byte address; stable while i_req is high
- i_rdata  output  WIDTH  fetched instruction; valid when i_ready is high, then held
- i_ready  output  1  one-cycle completion pulse for I
- d_req  input  1  data request; held high until d_ready
- d_we  input  1  1 = write, 0 = read; stable while d_req is high
- d_addr  input  WIDTH  data byte address
- d_wdata  input  WIDTH  write data
- d_rdata  output  WIDTH  load data; valid when d_ready is high, then held
- d_ready  output  1  one-cycle completion pulse for D
- m_en  output  1  memory access active
- m_we  output  1  memory write strobe
- m_addr  output  WIDTH  memory byte address
- m_wdata  output  WIDTH  memory write data
- m_rdata  input  WIDTH  memory read data; combinational from m_addr
- stall_f  output  1  i_req & ~i_ready
- stall_m  output  1  d_req & ~d_ready

Behaviour:
- Reset:
  - State IDLE, counter 0, last_grant = I.
  - i_rdata, d_rdata, m_addr and m_wdata are 0.
  - i_ready, d_ready, m_en and m_we are 0.
- States:
  - IDLE: arbitrate.
  - BUSY: memory access in progress.
  - DONE: completion cycle.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D, unless last_grant = D, in which case grant I. This alternates and prevents starvation in either direction.
  - On grant: latch owner, address, we (forced to 0 for I) and wdata; update last_grant; counter := LATENCY-1; go to BUSY.
- BUSY:
  - m_en = 1; m_addr and m_wdata come from the latched values.
  - m_we = latched we only in the final BUSY cycle (counter == 0), so a write happens exactly once.
  - Counter decrements each cycle.
  - At counter == 0: capture m_rdata into the owner's rdata register (reads only; the register is unchanged on a write), then go to DONE.
- DONE:
  - Owner's ready = 1 for exactly one cycle; m_en = 0; go to IDLE.
  - No arbitration in DONE, so the requester's stale req is never regranted.
- Outside BUSY, m_en, m_we, m_addr and m_wdata are 0.
- Latency: grant cycle, then LATENCY BUSY cycles, then the DONE cycle, so ready occurs in cycle LATENCY+1 counting the grant cycle as 0. The next grant is possible in cycle LATENCY+2.
- Requests arriving during BUSY or DONE wait; a requester that is not granted sees its stall held high.
- Requests are never dropped or reordered within a port.
- Changes to a requester's inputs after grant are ignored, because the values are latched.
- Reset during BUSY:
  - The transaction is aborted and no m_we pulse is issued if reset arrives before the final BUSY cycle.
  - All outputs return to their reset values immediately (asynchronous reset).
- Address: the block does not shift addresses; the memory uses m_addr[WIDTH-1:2]. Misalignment is not checked.
- The counter is 4 bits wide.

Test Plan:
- LATENCY=2, i_req=1, i_addr=0x8, m_rdata=0x20020005 -> m_en high in cycles 1–2 with m_addr=0x8; i_ready pulse in cycle 3 with i_rdata=0x20020005; stall_f high in cycles 0–2.
- d_req with d_we=1, d_addr=0x54, d_wdata=0xDEADBEEF -> m_we high only in cycle 2; d_ready in cycle 3; i_rdata and d_rdata unchanged. A following read of 0x54 returns d_rdata=0xDEADBEEF.
- i_req and d_req both raised in cycle 0 from reset -> D granted first (d_ready in cycle 3); I granted in cycle 4 (i_ready in cycle 7).
- d_req held continuously for 3 transactions with i_req pending -> grant order D, I, D, I; stall_f never high for more than 8 consecutive cycles.
- Write granted, reset asserted in cycle 1 (first BUSY cycle) -> m_we never high; all outputs 0; a new d_req after reset completes normally.
- LATENCY=1, back-to-back i_req -> m_en for 1 cycle, i_ready every 3 cycles, no duplicate grant of the same request.
